axis_demux_2: RTL and testbench
===============================

Name: axis_demux_2

Overview:
- AXI4-Stream 1-to-2 frame-aware demultiplexer; the distribution-side counterpart of the 2-port arbitrated mux.
- Routing is decided once per frame from the MSB of s_axis_tdest on the frame's first beat; the whole frame goes to that output or is dropped.
- Each output has its own registered skid stage, so every output signal is driven from a flop.
- Used to split the shared PTP/MAC stream back into per-consumer streams.

Parameters:
- DATA_WIDTH, 8, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- ID_ENABLE, 0, propagate tid.
- ID_WIDTH, 8, tid width.
- DEST_WIDTH, 8, tdest width (>=1); MSB selects the output.
- USER_ENABLE, 1, propagate tuser.
- USER_WIDTH, 1, tuser width.
- LAST_ENABLE, 1, honour tlast; when 0, every beat is a one-beat frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  DATA/KEEP/1/1/1/ID/DEST/USER widths  input stream
- m00_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  same widths  output 0 (select=0)
- m01_axis_* same set  output 1 (select=1)
- enable  in  1  permit starting a new frame
- drop  in  1  discard the frame being started

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, s_axis_tready=0, m00/m01 tvalid=0, temp-valid=0, select_reg=0, drop_reg=0. Data registers are don't-care but are held at 0 for lint cleanliness.
- Accept: a beat transfers when s_axis_tvalid && s_axis_tready.
- IDLE:
  - s_axis_tready=0.
  - If enable && s_axis_tvalid: select_reg<=s_axis_tdest[DEST_WIDTH-1], drop_reg<=drop, go to ACTIVE. The beat is not consumed in this cycle.
  - This gives a fixed 1-cycle bubble per frame.
- ACTIVE:
  - s_axis_tready = drop_reg | ready_early[select_reg].
  - On an accepted beat with tlast (or any accepted beat if LAST_ENABLE=0), go to IDLE.
  - enable, drop and tdest are ignored mid-frame. tdest may change within a frame without effect.
- Drop: beats are consumed at full rate with tready=1 and never appear on either output.
- Output stage, per port (own output register plus temp register):
  - ready_early = m_tready | (~temp_valid & (~m_tvalid | ~in_valid)).
  - in_valid = accepted beat && ~drop_reg && select_reg==port.
  - Latency from input accept to m_tvalid is 1 cycle.
  - The stage holds at most 2 beats. Full throughput with sustained tready.
  - tvalid must not drop while tready=0; data is stable while stalled.
- Non-selected port: receives nothing; it still drains beats already buffered from an earlier frame independently.
- Pass-through fields: tkeep/tid/tuser/tdest pass unchanged when enabled. Disabled fields drive constants: tkeep all-ones, others 0. tlast is driven 1 when LAST_ENABLE=0.
- Back-to-back frames: tlast accepted in cycle N → IDLE in N+1, latch in N+1, first beat accepted no earlier than N+2.
- Reset mid-frame: frame state and buffered beats are discarded and outputs go invalid immediately; upstream is responsible for re-sync.

Decomposition:
- No shared package: no shared typedefs exist. Select index and state encoding are local constants.
- One sub-module: axis_demux_out_reg, the per-port output/temp skid register, instantiated twice.

Test Plan:
- Single 4-beat frame, tdest=8'h80, m01 tready=1 → m01 sees 4 beats with tlast on the 4th; m00 tvalid stays 0. First output 2 cycles after s_axis_tvalid rise (1 bubble + 1 register).
- Two back-to-back 3-beat frames, tdest 8'h00 then 8'h80 → frame A on m00 and frame B on m01, in order, with exactly one idle cycle between the frames at the input.
- drop=1 at start of a 5-beat frame → s_axis_tready=1 for 5 consecutive cycles; no tvalid on either output; next frame with drop=0 routes normally.
- m00 tready toggles 1/0 every cycle during a 16-beat frame with data 0..15 → m00 receives 0..15 in order with no loss or duplication, and tvalid never deasserts while stalled.
- Frame started with enable=1, then enable=0 at beat 2 → frame completes; a following frame is not started (tready=0) until enable=1.
- Assert rst_n=0 at beat 2 of a frame with m00 stalled → m00 tvalid=0 and s_axis_tready=0 immediately; after release a new frame routes correctly.

Source files
------------

// File: rtl/axis_demux_out_reg.sv
// Per-port output skid stage: an output register plus one temp register,
// with a registered ready so the upstream handshake never sees a combinational loop.
module axis_demux_out_reg #(
    parameter int PAYLOAD_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [PAYLOAD_WIDTH-1:0] m_payload,
    output logic                     m_valid,
    input  logic                     m_ready
);

    logic                     ready_reg;
    logic                     ready_early;
    logic                     out_valid_reg;
    logic                     out_valid_next;
    logic                     temp_valid_reg;
    logic                     temp_valid_next;
    logic [PAYLOAD_WIDTH-1:0] out_payload_reg;
    logic [PAYLOAD_WIDTH-1:0] temp_payload_reg;
    logic                     store_in_to_out;
    logic                     store_in_to_temp;
    logic                     store_temp_to_out;

    // Ready for next cycle: downstream drains, or the temp slot cannot be needed.
    always_comb begin
        ready_early = m_ready | (~temp_valid_reg & (~out_valid_reg | ~in_valid));
    end

    // Steer the incoming beat into the output or temp slot, or refill output from temp.
    always_comb begin
        out_valid_next    = out_valid_reg;
        temp_valid_next   = temp_valid_reg;
        store_in_to_out   = 1'b0;
        store_in_to_temp  = 1'b0;
        store_temp_to_out = 1'b0;
        if (ready_reg) begin
            if (m_ready || !out_valid_reg) begin
                out_valid_next  = in_valid;
                store_in_to_out = 1'b1;
            end else begin
                temp_valid_next  = in_valid;
                store_in_to_temp = 1'b1;
            end
        end else if (m_ready) begin
            out_valid_next    = temp_valid_reg;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end else begin
            out_valid_next  = out_valid_reg;
            temp_valid_next = temp_valid_reg;
        end
    end

    // Valid flags and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            temp_valid_reg <= 1'b0;
        end else begin
            ready_reg      <= ready_early;
            out_valid_reg  <= out_valid_next;
            temp_valid_reg <= temp_valid_next;
        end
    end

    // Payload registers; only the valid flags carry meaning after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_payload_reg  <= {PAYLOAD_WIDTH{1'b0}};
            temp_payload_reg <= {PAYLOAD_WIDTH{1'b0}};
        end else begin
            if (store_in_to_out) begin
                out_payload_reg <= in_payload;
            end else if (store_temp_to_out) begin
                out_payload_reg <= temp_payload_reg;
            end else begin
                out_payload_reg <= out_payload_reg;
            end
            if (store_in_to_temp) begin
                temp_payload_reg <= in_payload;
            end else begin
                temp_payload_reg <= temp_payload_reg;
            end
        end
    end

    assign in_ready  = ready_reg;
    assign m_payload = out_payload_reg;
    assign m_valid   = out_valid_reg;

endmodule

// File: rtl/axis_demux_2.sv
// AXI4-Stream 1-to-2 frame-aware demultiplexer: the output is chosen from the
// MSB of tdest on a frame's first beat, and the whole frame is routed or dropped.
module axis_demux_2 #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter bit LAST_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic                  m00_axis_tlast,
    output logic [ID_WIDTH-1:0]   m00_axis_tid,
    output logic [DEST_WIDTH-1:0] m00_axis_tdest,
    output logic [USER_WIDTH-1:0] m00_axis_tuser,

    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m01_axis_tkeep,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,
    output logic                  m01_axis_tlast,
    output logic [ID_WIDTH-1:0]   m01_axis_tid,
    output logic [DEST_WIDTH-1:0] m01_axis_tdest,
    output logic [USER_WIDTH-1:0] m01_axis_tuser,

    input  logic                  enable,
    input  logic                  drop
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam int USER_LSB = 0;
    localparam int DEST_LSB = USER_LSB + USER_WIDTH;
    localparam int ID_LSB   = DEST_LSB + DEST_WIDTH;
    localparam int LAST_BIT = ID_LSB + ID_WIDTH;
    localparam int KEEP_LSB = LAST_BIT + 1;
    localparam int DATA_LSB = KEEP_LSB + KEEP_WIDTH;
    localparam int PW       = DATA_LSB + DATA_WIDTH;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          select_reg;
    logic          select_next;
    logic          drop_reg;
    logic          drop_next;
    logic          accept;
    logic          beat_last;
    logic          ready_int0;
    logic          ready_int1;
    logic          in_valid0;
    logic          in_valid1;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload0;
    logic [PW-1:0] out_payload1;

    assign s_axis_tready = (state == ACTIVE) &&
                           (drop_reg || (select_reg ? ready_int1 : ready_int0));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign beat_last     = LAST_ENABLE ? s_axis_tlast : 1'b1;
    assign in_valid0     = accept && !drop_reg && (select_reg == 1'b0);
    assign in_valid1     = accept && !drop_reg && (select_reg == 1'b1);

    assign in_payload = {s_axis_tdata,
                         (KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}}),
                         beat_last,
                         (ID_ENABLE ? s_axis_tid : {ID_WIDTH{1'b0}}),
                         s_axis_tdest,
                         (USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}})};

    // Frame FSM: latch route and drop on the first beat, release after the last beat.
    always_comb begin
        state_next  = state;
        select_next = select_reg;
        drop_next   = drop_reg;
        case (state)
            IDLE: begin
                if (enable && s_axis_tvalid) begin
                    state_next  = ACTIVE;
                    select_next = s_axis_tdest[DEST_WIDTH-1];
                    drop_next   = drop;
                end else begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (accept && beat_last) begin
                    state_next = IDLE;
                end else begin
                    state_next = ACTIVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            select_reg <= 1'b0;
            drop_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            select_reg <= select_next;
            drop_reg   <= drop_next;
        end
    end

    axis_demux_out_reg #(
        .PAYLOAD_WIDTH (PW)
    ) u_out0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_payload (in_payload),
        .in_valid   (in_valid0),
        .in_ready   (ready_int0),
        .m_payload  (out_payload0),
        .m_valid    (m00_axis_tvalid),
        .m_ready    (m00_axis_tready)
    );

    axis_demux_out_reg #(
        .PAYLOAD_WIDTH (PW)
    ) u_out1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_payload (in_payload),
        .in_valid   (in_valid1),
        .in_ready   (ready_int1),
        .m_payload  (out_payload1),
        .m_valid    (m01_axis_tvalid),
        .m_ready    (m01_axis_tready)
    );

    // Disabled sideband fields present constants regardless of register contents.
    assign m00_axis_tdata = out_payload0[DATA_LSB +: DATA_WIDTH];
    assign m00_axis_tkeep = KEEP_ENABLE ? out_payload0[KEEP_LSB +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
    assign m00_axis_tlast = LAST_ENABLE ? out_payload0[LAST_BIT] : 1'b1;
    assign m00_axis_tid   = ID_ENABLE ? out_payload0[ID_LSB +: ID_WIDTH] : {ID_WIDTH{1'b0}};
    assign m00_axis_tdest = out_payload0[DEST_LSB +: DEST_WIDTH];
    assign m00_axis_tuser = USER_ENABLE ? out_payload0[USER_LSB +: USER_WIDTH] : {USER_WIDTH{1'b0}};

    assign m01_axis_tdata = out_payload1[DATA_LSB +: DATA_WIDTH];
    assign m01_axis_tkeep = KEEP_ENABLE ? out_payload1[KEEP_LSB +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
    assign m01_axis_tlast = LAST_ENABLE ? out_payload1[LAST_BIT] : 1'b1;
    assign m01_axis_tid   = ID_ENABLE ? out_payload1[ID_LSB +: ID_WIDTH] : {ID_WIDTH{1'b0}};
    assign m01_axis_tdest = out_payload1[DEST_LSB +: DEST_WIDTH];
    assign m01_axis_tuser = USER_ENABLE ? out_payload1[USER_LSB +: USER_WIDTH] : {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_demux_2.sv
// Scoreboard bench for axis_demux_2: the driver pushes expected beats per port,
// and a negedge monitor pops and compares whatever each output delivers.
module tb_axis_demux_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic [0:0] s_tkeep;
    logic       s_tvalid;
    logic       s_axis_tready;
    logic       s_tlast;
    logic [7:0] s_tid;
    logic [7:0] s_tdest;
    logic [0:0] s_tuser;
    logic [7:0] m00_tdata, m01_tdata;
    logic [0:0] m00_tkeep, m01_tkeep;
    logic       m00_tvalid, m01_tvalid;
    logic       m00_tready, m01_tready;
    logic       m00_tlast, m01_tlast;
    logic [7:0] m00_tid, m01_tid;
    logic [7:0] m00_tdest, m01_tdest;
    logic [0:0] m00_tuser, m01_tuser;
    logic       enable;
    logic       drop;
    logic       toggle_en;
    logic       tog;
    logic       m00_rdy_base;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] dest;
        logic       user;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    logic  prev_stall0 = 1'b0, prev_stall1 = 1'b0;
    beat_t prev_beat0, prev_beat1;
    logic  lat_arm = 1'b0;
    int    lat_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tog <= ~tog;

    assign m00_tready = toggle_en ? tog : m00_rdy_base;
    assign m01_tready = 1'b1;

    axis_demux_2 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_tlast),
        .s_axis_tid      (s_tid),
        .s_axis_tdest    (s_tdest),
        .s_axis_tuser    (s_tuser),
        .m00_axis_tdata  (m00_tdata),
        .m00_axis_tkeep  (m00_tkeep),
        .m00_axis_tvalid (m00_tvalid),
        .m00_axis_tready (m00_tready),
        .m00_axis_tlast  (m00_tlast),
        .m00_axis_tid    (m00_tid),
        .m00_axis_tdest  (m00_tdest),
        .m00_axis_tuser  (m00_tuser),
        .m01_axis_tdata  (m01_tdata),
        .m01_axis_tkeep  (m01_tkeep),
        .m01_axis_tvalid (m01_tvalid),
        .m01_axis_tready (m01_tready),
        .m01_axis_tlast  (m01_tlast),
        .m01_axis_tid    (m01_tid),
        .m01_axis_tdest  (m01_tdest),
        .m01_axis_tuser  (m01_tuser),
        .enable          (enable),
        .drop            (drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: stall stability, then pop-and-compare on every output handshake.
    always @(negedge clk) begin
        beat_t b0, b1, e;
        b0 = '{data: m00_tdata, last: m00_tlast, dest: m00_tdest, user: m00_tuser[0]};
        b1 = '{data: m01_tdata, last: m01_tlast, dest: m01_tdest, user: m01_tuser[0]};
        if (!rst_n) begin
            prev_stall0 = 1'b0;
            prev_stall1 = 1'b0;
        end else begin
            if (prev_stall0) begin
                check("m00_stall_valid", {31'd0, m00_tvalid}, 32'd1);
                check("m00_stall_data", {14'd0, b0}, {14'd0, prev_beat0});
            end
            if (prev_stall1) begin
                check("m01_stall_valid", {31'd0, m01_tvalid}, 32'd1);
                check("m01_stall_data", {14'd0, b1}, {14'd0, prev_beat1});
            end
            if (m00_tvalid && m00_tready) begin
                if (q0.size() == 0) begin
                    check("m00_unexpected_beat", {14'd0, b0}, 32'hFFFF_FFFF);
                end else begin
                    e = q0.pop_front();
                    check("m00_beat", {14'd0, b0}, {14'd0, e});
                end
            end
            if (m01_tvalid && m01_tready) begin
                if (q1.size() == 0) begin
                    check("m01_unexpected_beat", {14'd0, b1}, 32'hFFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    check("m01_beat", {14'd0, b1}, {14'd0, e});
                end
            end
            if (lat_arm && m01_tvalid) begin
                lat_cyc = cyc;
                lat_arm = 1'b0;
            end
            prev_stall0 = m00_tvalid && !m00_tready;
            prev_stall1 = m01_tvalid && !m01_tready;
            prev_beat0  = b0;
            prev_beat1  = b1;
        end
    end

    task automatic push_exp(input logic [7:0] ds, input logic [7:0] d, input logic l, input logic u);
        beat_t e;
        e = '{data: d, last: l, dest: ds, user: u};
        if (ds[7]) q1.push_back(e);
        else       q0.push_back(e);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic [7:0] ds,
                             input logic u, output int waits, output int acc_cyc);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tdest  = ds;
        s_tuser  = u;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            waits++;
            if (waits > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ds, input logic dr, input int n, input logic [7:0] base,
                              output int first_acc, output int last_acc, output int max_wait);
        int w, a;
        max_wait = 0;
        first_acc = 0;
        a = 0;
        drop = dr;
        for (int i = 0; i < n; i++) begin
            if (!dr) push_exp(ds, base + 8'(i), (i == n - 1), (i == 0));
            send_beat(base + 8'(i), (i == n - 1), ds, (i == 0), w, a);
            if (i == 0) first_acc = a;
            else if (w > max_wait) max_wait = w;
        end
        last_acc = a;
        drop = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_q0_empty", q0.size(), 32'd0);
        check("drain_q1_empty", q1.size(), 32'd0);
    endtask

    initial begin
        int fa, la, fb, lb, mw, t0, w, a;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tkeep = 1'b1; s_tlast = 1'b0;
        s_tid = 8'h00; s_tdest = 8'h00; s_tuser = 1'b0; enable = 1'b1; drop = 1'b0;
        toggle_en = 1'b0; tog = 1'b0; m00_rdy_base = 1'b1;
        #12;
        check("reset_s_tready", {31'd0, s_axis_tready}, 32'd0);
        check("reset_m00_tvalid", {31'd0, m00_tvalid}, 32'd0);
        check("reset_m01_tvalid", {31'd0, m01_tvalid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single 4-beat frame to m01, checking the bubble + register latency.
        t0 = cyc;
        lat_arm = 1'b1;
        send_frame(8'h80, 1'b0, 4, 8'h10, fa, la, mw);
        check("t1_first_accept_latency", fa - t0, 32'd2);
        check("t1_output_latency", lat_cyc - t0, 32'd2);

        // Back-to-back frames with exactly one idle input cycle between them.
        send_frame(8'h00, 1'b0, 3, 8'h20, fa, la, mw);
        send_frame(8'h80, 1'b0, 3, 8'h30, fb, lb, mw);
        check("t2_gap_between_frames", fb - la, 32'd2);

        // Dropped 5-beat frame is consumed at full rate, then normal routing resumes.
        send_frame(8'h80, 1'b1, 5, 8'h50, fa, la, mw);
        check("t3_drop_no_wait", mw, 32'd0);
        check("t3_drop_span", la - fa, 32'd4);
        send_frame(8'h81, 1'b0, 2, 8'h60, fa, la, mw);

        // 16-beat frame to m00 with tready toggling every cycle.
        toggle_en = 1'b1;
        send_frame(8'h00, 1'b0, 16, 8'h00, fa, la, mw);
        wait_drain();
        toggle_en = 1'b0;

        // enable deasserted mid-frame: frame completes, next one waits for enable.
        for (int i = 0; i < 4; i++) begin
            if (i == 2) enable = 1'b0;
            push_exp(8'h80, 8'hC0 + 8'(i), (i == 3), (i == 0));
            send_beat(8'hC0 + 8'(i), (i == 3), 8'h80, (i == 0), w, a);
        end
        s_tvalid = 1'b1; s_tdata = 8'hD0; s_tdest = 8'h00; s_tlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_hold_without_enable", {31'd0, s_axis_tready}, 32'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        send_frame(8'h00, 1'b0, 3, 8'hD0, fa, la, mw);
        wait_drain();

        // Reset mid-frame with m00 stalled.
        m00_rdy_base = 1'b0;
        send_beat(8'hE0, 1'b0, 8'h00, 1'b1, w, a);
        send_beat(8'hE1, 1'b0, 8'h00, 1'b0, w, a);
        s_tvalid = 1'b1; s_tdata = 8'hE2; s_tlast = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_stalled_tready", {31'd0, s_axis_tready}, 32'd0);
            check("t6_stalled_m00_valid", {31'd0, m00_tvalid}, 32'd1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_reset_m00_tvalid", {31'd0, m00_tvalid}, 32'd0);
        check("t6_reset_s_tready", {31'd0, s_axis_tready}, 32'd0);
        s_tvalid = 1'b0;
        m00_rdy_base = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h00, 1'b0, 2, 8'h90, fa, la, mw);
        send_frame(8'h80, 1'b0, 2, 8'hA0, fa, la, mw);

        wait_drain();
        check("m00_tkeep_const", {31'd0, m00_tkeep}, 32'd1);
        check("m01_tkeep_const", {31'd0, m01_tkeep}, 32'd1);
        check("m00_tid_const", {24'd0, m00_tid}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
